// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl: two-requester round-robin front end that computes a
// WIDTH-bit add over several cycles on one shared SLICE_W-bit ripple slice.
// Optional feature macro: ADDER_SHARE_OVF_EN adds the rsp_ovf signed-overflow output.

module sixteen_bit_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  // Bit-serial ripple chain; the carry variable walks LSB to MSB.
  always_comb begin
    logic c;
    o_sum = '0;
    c     = i_cin;
    for (int i = 0; i < W; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ c;
      c        = (i_a[i] & i_b[i]) | (c & (i_a[i] ^ i_b[i]));
    end
    o_cout = c;
  end

endmodule

module adder_share_ctrl #(
  parameter int WIDTH   = 64,
  parameter int SLICE_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
`ifdef ADDER_SHARE_OVF_EN
  output logic             rsp_ovf,
`endif
  output logic             rsp_cout
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic [KW-1:0]      r_k;
  logic               r_carry;
  logic               r_id;
  logic               r_last_grant;
  logic               r_rsp_valid;
  logic               r_cout;
`ifdef ADDER_SHARE_OVF_EN
  logic               r_ovf;
`endif

  logic               w_grant;
  logic               w_accept;
  logic               w_last_slice;
  logic [SLICE_W-1:0] w_slice_a;
  logic [SLICE_W-1:0] w_slice_b;
  logic [SLICE_W-1:0] w_slice_sum;
  logic               w_slice_cout;

  // Round-robin pick: a lone requester wins, contention goes to the one not served last.
  always_comb begin
    w_grant = 1'b0;
    case ({req1_valid, req0_valid})
      2'b01:   w_grant = 1'b0;
      2'b10:   w_grant = 1'b1;
      2'b11:   w_grant = ~r_last_grant;
      default: w_grant = 1'b0;
    endcase
  end

  // Handshake decode; nothing is offered outside IDLE or while reset is held.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if ((r_state == S_IDLE) && !rst) begin
      req0_ready = (w_grant == 1'b0) && req0_valid;
      req1_ready = (w_grant == 1'b1) && req1_valid;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  assign w_accept     = req0_ready | req1_ready;
  assign w_last_slice = (r_k == KW'(NSLICE - 1));
  assign w_slice_a    = r_a[r_k*SLICE_W +: SLICE_W];
  assign w_slice_b    = r_b[r_k*SLICE_W +: SLICE_W];

  sixteen_bit_adder #(
    .W (SLICE_W)
  ) u_slice (
    .i_a    (w_slice_a),
    .i_b    (w_slice_b),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: accept -> one CALC cycle per slice -> hold DONE until consumed.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_CALC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        if (w_last_slice) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_CALC;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then fold one slice per CALC cycle into r_sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a          <= '0;
      r_b          <= '0;
      r_sum        <= '0;
      r_k          <= '0;
      r_carry      <= 1'b0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_cout       <= 1'b0;
`ifdef ADDER_SHARE_OVF_EN
      r_ovf        <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_a          <= w_grant ? req1_a : req0_a;
        r_b          <= w_grant ? req1_b : req0_b;
        r_carry      <= w_grant ? req1_cin : req0_cin;
        r_id         <= w_grant;
        r_last_grant <= w_grant;
        r_k          <= '0;
      end else if (r_state == S_CALC) begin
        r_sum[r_k*SLICE_W +: SLICE_W] <= w_slice_sum;
        r_carry <= w_slice_cout;
        r_k     <= r_k + KW'(1);
        if (w_last_slice) begin
          r_rsp_valid <= 1'b1;
          r_cout      <= w_slice_cout;
`ifdef ADDER_SHARE_OVF_EN
          // Same-sign operands whose result sign differs from theirs.
          r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                         (w_slice_sum[SLICE_W-1] != r_a[WIDTH-1]);
`endif
        end
      end else if ((r_state == S_DONE) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_id;
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;
`ifdef ADDER_SHARE_OVF_EN
  assign rsp_ovf   = r_ovf;
`endif

endmodule
